sqrt_pwl_pipe: RTL
==================

Name: sqrt_pwl_pipe

Overview:
- Parametrised piecewise-linear square-root unit: y = K[idx]*off + B[idx], evaluated through a 3-stage pipeline.
- Coefficients live in an internal RAM that is runtime-loadable, replacing the fixed K/B ROMs of the previous generation.
- Adds ready/valid backpressure, rounding, saturation with a flag, and safe coefficient reload (the pipeline drains first).
- Sits in the image/feature datapath wherever magnitude = sqrt(sum of squares) is needed.

Parameters:
- DIN_W, 16, input word width (unsigned).
- SEG_BITS, 10, segment index bits; the table has 2^SEG_BITS entries.
- K_W, 20, slope coefficient width (unsigned, Q(K_W-SHIFT).SHIFT).
- B_W, 16, intercept width (unsigned, Q(B_W-(SHIFT-OFF_W)).(SHIFT-OFF_W)).
- SHIFT, 14, fractional bits of the full-precision sum removed at the output.
- DOUT_W, 8, output width (unsigned).
- Derived: OFF_W = DIN_W-SEG_BITS (6 at defaults); FULL_W = max(K_W+OFF_W, B_W+OFF_W)+1.

Ports:
- clk, in, 1, clock.
- rst, in, 1, synchronous active-high reset.
- in_data, in, DIN_W, radicand.
- in_valid, in, 1, input valid.
- in_ready, out, 1, input accepted when in_valid && in_ready.
- out_data, out, DOUT_W, rounded and saturated sqrt.
- out_sat, out, 1, out_data was clipped to the maximum value.
- out_valid, out, 1, output valid.
- out_ready, in, 1, downstream accepts.
- cfg_we, in, 1, coefficient write request.
- cfg_addr, in, SEG_BITS, segment to write.
- cfg_k, in, K_W, slope.
- cfg_b, in, B_W, intercept.
- cfg_ready, out, 1, write accepted when cfg_we && cfg_ready.

Behaviour:
- Reset: out_valid=0, out_data=0, out_sat=0, all stage valid bits 0, in_ready=0 during reset, cfg_ready=0 during reset. Coefficient RAM contents are NOT cleared by reset.
- Index and offset: idx = in_data[DIN_W-1 -: SEG_BITS]; off = in_data[OFF_W-1:0].
- Stage 1: register idx, off and valid; issue the RAM read (synchronous read).
- Stage 2: RAM data is available; register prod = K*off (K_W+OFF_W bits) and B.
- Stage 3: sum = prod + (B << OFF_W) at FULL_W bits, no overflow.
  - r = (sum + (1 << (SHIFT-1))) >> SHIFT.
  - If r > 2^DOUT_W-1, out_data = all ones and out_sat=1; otherwise out_data=r and out_sat=0.
- Latency: 3 clk from input acceptance to out_valid, with out_ready held high. Throughput is 1 sample/clk.
- Backpressure:
  - adv = !out_valid || out_ready. All stages, including the RAM read-enable, advance only when adv=1.
  - On a stall, every stage holds and out_data/out_sat remain stable while out_valid=1.
  - Bubbles are not compressed; a stall freezes the whole pipe.
- in_ready = adv && !cfg_we && !rst.
- Config handshake:
  - cfg_ready = !rst && (no valid in stage 1, stage 2 or the output register) && !(in_valid && in_ready).
  - While cfg_we=1, in_ready=0, so the pipe drains; cfg_ready rises once it is empty.
  - A write commits at the clock edge where cfg_we && cfg_ready. The next accepted sample sees the new coefficient.
  - Back-to-back writes are allowed at 1 per clk.
- Simultaneous in_valid and cfg_we: config has priority and the input is refused.
- Reset mid-operation: in-flight samples are discarded and no out_valid is emitted afterward for them.
- No combinational path from in_valid to out_valid. The out_ready→in_ready path is combinational and permitted.

Test Plan:
- Load addr 4: K=483, B=0x1000. Send in_data=288 (idx 4, off 32) with out_ready=1.
  - Expect out_valid exactly 3 clk after acceptance, out_data=17, out_sat=0.
- Same table entry, in_data=256 (off 0).
  - Expect out_data=16. For in_data=319: sum=483*63+262144=292573, so r=18 (292573+8192=300765>>14=18).
- Load addr 1023: K=0xFFFFF, B=0xFFFF. Send in_data=0xFFFF.
  - Expect out_data=255, out_sat=1.
- Stream 8 samples back-to-back; hold out_ready=0 for 4 clk mid-stream.
  - Expect in_ready=0 during the stall and out_data held stable.
  - Expect no loss or duplication; outputs appear in order; 8 outputs total.
- With 2 samples in flight, assert cfg_we for addr 4 with K=0, B=0x2000.
  - Expect cfg_ready=0 until both samples exit with the old coefficients (17 for 288).
  - After the write, 288 gives 32.
- Assert rst for 1 clk with 3 samples in flight.
  - Expect out_valid=0 next clk and no stale outputs.
  - RAM retains addr 4; a re-sent 288 still gives the last loaded value.

Source files
------------

// File: rtl/sqrt_pwl_pipe.sv
// Piecewise-linear square root, y = K[idx]*off + B[idx], in a 3-stage ready/valid pipeline.
// The coefficient RAM is loaded at runtime through a cfg port that waits for the pipe to drain.
module sqrt_pwl_pipe #(
    parameter int unsigned DIN_W    = 16,
    parameter int unsigned SEG_BITS = 10,
    parameter int unsigned K_W      = 20,
    parameter int unsigned B_W      = 16,
    parameter int unsigned SHIFT    = 14,
    parameter int unsigned DOUT_W   = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [DIN_W-1:0]    in_data,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [DOUT_W-1:0]   out_data,
    output logic                out_sat,
    output logic                out_valid,
    input  logic                out_ready,
    input  logic                cfg_we,
    input  logic [SEG_BITS-1:0] cfg_addr,
    input  logic [K_W-1:0]      cfg_k,
    input  logic [B_W-1:0]      cfg_b,
    output logic                cfg_ready
);

    localparam int unsigned OFF_W  = DIN_W - SEG_BITS;
    localparam int unsigned PROD_W = K_W + OFF_W;
    localparam int unsigned FULL_W = ((K_W > B_W) ? K_W : B_W) + OFF_W + 1;
    localparam int unsigned RND_W  = FULL_W + 1;
    localparam int unsigned R_W    = RND_W - SHIFT;
    localparam int unsigned DEPTH  = 1 << SEG_BITS;
    localparam int unsigned MAXV   = (1 << DOUT_W) - 1;

    logic [K_W+B_W-1:0]  r_mem [DEPTH];
    logic [K_W+B_W-1:0]  r_ram_q;

    logic                r_s1_valid;
    logic [OFF_W-1:0]    r_s1_off;
    logic                r_s2_valid;
    logic [PROD_W-1:0]   r_s2_prod;
    logic [B_W-1:0]      r_s2_b;
    logic                r_out_valid;
    logic [DOUT_W-1:0]   r_out_data;
    logic                r_out_sat;

    logic                w_adv;
    logic                w_accept;
    logic                w_cfg_fire;
    logic [SEG_BITS-1:0] w_idx;
    logic [OFF_W-1:0]    w_off;
    logic [K_W-1:0]      w_k;
    logic [B_W-1:0]      w_b;
    logic [PROD_W-1:0]   w_prod;
    logic [FULL_W-1:0]   w_sum;
    logic [RND_W-1:0]    w_rnd;
    logic [R_W-1:0]      w_r;
    logic                w_sat;
    logic [DOUT_W-1:0]   w_dout;

    // Handshake: the whole pipe advances together, config wins over data.
    always_comb begin
        w_adv      = !r_out_valid || out_ready;
        in_ready   = w_adv && !cfg_we && !rst;
        w_accept   = in_valid && in_ready;
        cfg_ready  = !rst && !r_s1_valid && !r_s2_valid && !r_out_valid && !w_accept;
        w_cfg_fire = cfg_we && cfg_ready;
    end

    assign w_idx = in_data[DIN_W-1 -: SEG_BITS];
    assign w_off = in_data[OFF_W-1:0];
    assign w_k   = r_ram_q[K_W+B_W-1 -: K_W];
    assign w_b   = r_ram_q[B_W-1:0];

    // Coefficient RAM: not cleared by reset; writes only land while the pipe is empty.
    always_ff @(posedge clk) begin
        if (w_cfg_fire) begin
            r_mem[cfg_addr] <= {cfg_k, cfg_b};
        end
    end

    always_ff @(posedge clk) begin
        if (w_adv) begin
            r_ram_q <= r_mem[w_idx];
        end
    end

    // Stage-3 arithmetic: full-precision sum, round half up, clip to the output range.
    always_comb begin
        w_prod = PROD_W'(w_k) * PROD_W'(r_s1_off);
        w_sum  = FULL_W'(r_s2_prod) + (FULL_W'(r_s2_b) << OFF_W);
        w_rnd  = RND_W'(w_sum) + (RND_W'(1) << (SHIFT - 1));
        w_r    = R_W'(w_rnd >> SHIFT);
        w_sat  = (w_r > R_W'(MAXV));
        w_dout = w_sat ? {DOUT_W{1'b1}} : DOUT_W'(w_r);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid  <= 1'b0;
            r_s1_off    <= '0;
            r_s2_valid  <= 1'b0;
            r_s2_prod   <= '0;
            r_s2_b      <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_sat   <= 1'b0;
        end else if (w_adv) begin
            r_s1_valid  <= w_accept;
            r_s1_off    <= w_off;
            r_s2_valid  <= r_s1_valid;
            r_s2_prod   <= w_prod;
            r_s2_b      <= w_b;
            r_out_valid <= r_s2_valid;
            if (r_s2_valid) begin
                r_out_data <= w_dout;
                r_out_sat  <= w_sat;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_sat   = r_out_sat;

endmodule
